// File: rtl/usb_tx_stream_if.sv
// Byte-stream handshake between a packet source and the USB line transmitter.
interface usb_tx_stream_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/usb_tx_stream.sv
// USB low-level packet transmitter: SYNC, NRZI-encoded bit-stuffed data, EOP.
// One line bit per clock; underrun mid-packet is signalled with a stuff-violation abort.
module usb_tx_stream #(
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           hold,
  usb_tx_stream_if.slave s_tx,
  output logic           dp,
  output logic           dm,
  output logic           tx_oe,
  output logic           busy,
  output logic           done,
  output logic           tx_err
);

  localparam int CNT_W  = $clog2(SYNC_BITS) + 1;
  localparam int ONES_W = $clog2(STUFF_LEN + 2);

  localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0]  BYTE_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ABORT_LAST = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0]  EOP_LAST   = CNT_W'(EOP_SE0_BITS - 1);
  localparam logic [ONES_W-1:0] STUFF_AT   = ONES_W'(STUFF_LEN);
  localparam logic [ONES_W-1:0] ONES_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_ABORT,
    S_EOP,
    S_EOPJ
  } state_t;

  // The state names what is on the line during the current cycle.
  state_t            r_state;
  state_t            r_ret_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [ONES_W-1:0] r_ones;
  logic [7:0]        r_shift;
  logic              r_last;
  logic              r_dp;
  logic              r_dm;
  logic              r_oe;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_next;
  state_t            w_nat_state;
  state_t            w_ret_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [ONES_W-1:0] w_ones_next;
  logic [ONES_W-1:0] w_ones_inc;
  logic [7:0]        w_shift_next;
  logic              w_last_next;
  logic              w_bit;
  logic              w_stuff_ok;
  logic              w_dp_next;
  logic              w_dm_next;
  logic              w_oe_next;
  logic              w_busy_next;
  logic              w_done_next;

  logic              w_run;
  logic              w_idle_offer;
  logic              w_byte_end;

  // Handshake strobes are decoded from registered state so the source sees them
  // in the very cycle the byte is taken (or found missing).
  assign w_run        = !hold && !rst_b;
  assign w_idle_offer = (r_state == S_IDLE) && s_tx.tx_valid;
  assign w_byte_end   = (r_state == S_DATA) && (r_bit_cnt == BYTE_LAST) && !r_last;

  assign s_tx.tx_ready = w_run && (w_idle_offer || (w_byte_end && s_tx.tx_valid));
  assign tx_err        = w_run && w_byte_end && !s_tx.tx_valid;

  assign dp    = r_dp;
  assign dm    = r_dm;
  assign tx_oe = r_oe;
  assign busy  = r_busy;
  assign done  = r_done && !hold;

  // State register: every piece of sequential state, frozen by hold.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_IDLE;
      r_bit_cnt   <= '0;
      r_ones      <= '0;
      r_shift     <= '0;
      r_last      <= 1'b0;
      r_dp        <= 1'b1;
      r_dm        <= 1'b0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (!hold) begin
      r_state     <= w_state_next;
      r_ret_state <= w_ret_next;
      r_bit_cnt   <= w_cnt_next;
      r_ones      <= w_ones_next;
      r_shift     <= w_shift_next;
      r_last      <= w_last_next;
      r_dp        <= w_dp_next;
      r_dm        <= w_dm_next;
      r_oe        <= w_oe_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state logic: pick the next bit to send, then decide whether a stuff
  // bit must be slipped in ahead of it.
  always_comb begin
    w_state_next = r_state;
    w_nat_state  = r_state;
    w_ret_next   = r_ret_state;
    w_cnt_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_last_next  = r_last;
    w_bit        = 1'b1;
    w_stuff_ok   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (s_tx.tx_valid) begin
          w_nat_state  = S_SYNC;
          w_cnt_next   = '0;
          w_shift_next = s_tx.tx_data;
          w_last_next  = s_tx.tx_last;
          w_bit        = (SYNC_LAST == '0);
        end
      end
      S_SYNC: begin
        w_stuff_ok = 1'b1;
        if (r_bit_cnt == SYNC_LAST) begin
          w_nat_state = S_DATA;
          w_cnt_next  = '0;
          w_bit       = r_shift[0];
        end else begin
          w_nat_state = S_SYNC;
          w_cnt_next  = r_bit_cnt + 1'b1;
          w_bit       = ((r_bit_cnt + 1'b1) == SYNC_LAST);
        end
      end
      S_DATA: begin
        w_stuff_ok = 1'b1;
        if (r_bit_cnt != BYTE_LAST) begin
          w_nat_state  = S_DATA;
          w_cnt_next   = r_bit_cnt + 1'b1;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit        = r_shift[1];
        end else if (r_last) begin
          w_nat_state = S_EOP;
          w_cnt_next  = '0;
        end else if (s_tx.tx_valid) begin
          w_nat_state  = S_DATA;
          w_cnt_next   = '0;
          w_shift_next = s_tx.tx_data;
          w_last_next  = s_tx.tx_last;
          w_bit        = s_tx.tx_data[0];
        end else begin
          // Underrun: a deliberate run of unstuffed ones marks the packet bad.
          w_nat_state = S_ABORT;
          w_cnt_next  = '0;
          w_stuff_ok  = 1'b0;
        end
      end
      S_STUFF: begin
        w_nat_state = r_ret_state;
        if (r_ret_state == S_SYNC) begin
          w_bit = (r_bit_cnt == SYNC_LAST);
        end else if (r_ret_state == S_DATA) begin
          w_bit = r_shift[0];
        end
      end
      S_ABORT: begin
        if (r_bit_cnt == ABORT_LAST) begin
          w_nat_state = S_EOP;
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      S_EOP: begin
        if (r_bit_cnt == EOP_LAST) begin
          w_nat_state = S_EOPJ;
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      S_EOPJ: begin
        w_nat_state = S_IDLE;
        w_cnt_next  = '0;
      end
      default: begin
        w_nat_state = S_IDLE;
        w_cnt_next  = '0;
      end
    endcase

    if (w_stuff_ok && (r_ones == STUFF_AT)) begin
      w_state_next = S_STUFF;
      w_ret_next   = w_nat_state;
    end else begin
      w_state_next = w_nat_state;
    end

    w_ones_inc  = (r_ones == ONES_MAX) ? r_ones : r_ones + 1'b1;
    w_ones_next = '0;
    if ((w_state_next == S_SYNC) || (w_state_next == S_DATA) || (w_state_next == S_ABORT)) begin
      w_ones_next = w_bit ? w_ones_inc : '0;
    end
  end

  // Output logic: NRZI-encode the chosen bit into the next registered line state.
  always_comb begin
    w_dp_next   = r_dp;
    w_dm_next   = r_dm;
    w_oe_next   = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (r_state == S_EOPJ);

    case (w_state_next)
      S_IDLE: begin
        w_dp_next = 1'b1;
        w_dm_next = 1'b0;
        w_oe_next = 1'b0;
      end
      S_SYNC, S_DATA, S_ABORT: begin
        if (!w_bit) begin
          w_dp_next = ~r_dp;
          w_dm_next = ~r_dm;
        end
      end
      S_STUFF: begin
        w_dp_next = ~r_dp;
        w_dm_next = ~r_dm;
      end
      S_EOP: begin
        w_dp_next = 1'b0;
        w_dm_next = 1'b0;
      end
      S_EOPJ: begin
        w_dp_next = 1'b1;
        w_dm_next = 1'b0;
      end
      default: begin
        w_dp_next = 1'b1;
        w_dm_next = 1'b0;
        w_oe_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_stream.sv
// Scoreboard bench for usb_tx_stream: expected line symbols are queued per packet,
// a negedge monitor pops and compares every driven line cycle.
module tb_usb_tx_stream;
  logic clk = 1'b0;
  logic rst_b;
  logic hold;
  logic dp, dm, tx_oe, busy, done, tx_err;

  usb_tx_stream_if bus ();

  usb_tx_stream dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .hold   (hold),
    .s_tx   (bus),
    .dp     (dp),
    .dm     (dm),
    .tx_oe  (tx_oe),
    .busy   (busy),
    .done   (done),
    .tx_err (tx_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line symbols as {dp,dm}: J = 2, K = 1, SE0 = 0.
  logic [1:0] exp_line[$];
  int         exp_len[$];
  int         run_len = 0;
  int         pkt_no = 0;
  logic       prev_oe = 1'b0;
  logic [1:0] mon_exp;
  int         mon_len;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "J")      exp_line.push_back(2'b10);
      else if (s[i] == "K") exp_line.push_back(2'b01);
      else                  exp_line.push_back(2'b00);
    end
  endtask

  task automatic push_pkt(input string s);
    push_line(s);
    exp_len.push_back(s.len());
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept(input string name, input logic [7:0] d, input logic l);
    int  n = 0;
    bit  got = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    while (!got && n < 20) begin
      #1;
      got = bus.tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.tx_valid = 1'b0;
    check({name, "_accepted"}, int'(got), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tx_oe) && n < 100) begin
      tick(1);
      n++;
    end
    check({name, "_idle_in_time"}, int'(n < 100), 1);
    check({name, "_done"}, done, 1);
    tick(1);
    check({name, "_done_clear"}, done, 0);
  endtask

  // Monitor: every tx_oe cycle consumes one expected symbol; the falling edge of
  // tx_oe closes the packet and checks its length and the done pulse.
  always @(negedge clk) begin
    if (tx_oe === 1'b1) begin
      if (exp_line.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL line_extra: got {dp,dm}=%0d with no symbol expected", {dp, dm});
      end else begin
        mon_exp = exp_line.pop_front();
        check($sformatf("line[%0d]", run_len), {dp, dm}, mon_exp);
      end
      run_len++;
    end else if (prev_oe === 1'b1) begin
      pkt_no++;
      if (exp_len.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pkt_unexpected: got %0d line cycles, expected no packet", run_len);
      end else begin
        mon_len = exp_len.pop_front();
        if (mon_len < 0) begin
          check("done_after_reset", done, 0);
        end else begin
          check("pkt_len", run_len, mon_len);
          check("done_pulse", done, 1);
        end
      end
      $display("packet %0d: %0d line cycles, done=%0b", pkt_no, run_len, done);
      run_len = 0;
    end
    prev_oe = tx_oe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_b        = 1'b1;
    hold         = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    tick(2);
    check("reset_state", {dp, dm, tx_oe, busy, done, bus.tx_ready, tx_err}, 7'b1000000);
    rst_b = 1'b0;
    tick(1);

    // 0x80 last: SYNC, one toggle run, EOP
    push_pkt("KJKJKJKKJKJKJKJJ00J");
    accept("pkt80", 8'h80, 1'b1);
    check("sync_oe_first", tx_oe, 1);
    wait_idle("pkt80");

    // 0xFF last: stuff after fifth data bit
    push_pkt("KJKJKJKKKKKKKJJJJ00J");
    accept("pktFF", 8'hFF, 1'b1);
    wait_idle("pktFF");

    // 0xFC last: stuff after the final bit, before EOP
    push_pkt("KJKJKJKKJKKKKKKKJ00J");
    accept("pktFC", 8'hFC, 1'b1);
    wait_idle("pktFC");

    // 0x00 then 0x55 back to back with tx_valid held
    push_pkt("KJKJKJKKJKJKJKJKKJJKKJJK00J");
    accept("pair0", 8'h00, 1'b0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h55;
    bus.tx_last  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      cnt += int'(bus.tx_ready);
      @(posedge clk);
      #1;
    end
    #1;
    check("pair_ready_early", cnt, 0);
    check("pair_ready_bit8", bus.tx_ready, 1);
    tick(1);
    bus.tx_valid = 1'b0;
    check("pair_ready_after", bus.tx_ready, 0);
    wait_idle("pair");

    // Underrun after a non-last byte: error pulse, abort run, EOP
    push_pkt("KJKJKJKKJKJKJKJKKKKKKKK00J");
    accept("under", 8'h00, 1'b0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      cnt += int'(tx_err);
      @(posedge clk);
      #1;
    end
    #1;
    check("under_err_early", cnt, 0);
    check("under_err_bit8", tx_err, 1);
    check("under_ready_bit8", bus.tx_ready, 0);
    tick(1);
    check("under_err_clear", tx_err, 0);
    wait_idle("under");

    // hold in IDLE blocks acceptance; hold mid-DATA stretches the packet by 3
    hold         = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h80;
    bus.tx_last  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold_no_ready", bus.tx_ready, 0);
      check("hold_idle_oe", tx_oe, 0);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    push_pkt("KJKJKJKKJKJKKKKJKJJ00J");
    accept("hold", 8'h80, 1'b1);
    tick(11);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    wait_idle("hold");

    // Reset during SYNC: line back to J, driver off, no EOP, no done
    push_line("KJK");
    exp_len.push_back(-1);
    accept("rst", 8'h80, 1'b1);
    tick(2);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    check("reset_mid_sync", {dp, dm, tx_oe, busy}, 4'b1000);
    tick(3);
    check("rst_no_restart", tx_oe, 0);

    check("exp_line_left", exp_line.size(), 0);
    check("exp_len_left", exp_len.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
